// File: rtl/bof_range_buffer.sv
// Range store behind the heap overflow tracker: ring of completed store ranges
// with newest-entry merge and same-cycle lookup for the load path.
module bof_range_buffer #(
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 32,
    parameter int MERGE_EN = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       en_write_i,
    input  logic [ADDR_W-1:0]          addr_first_i,
    input  logic [ADDR_W-1:0]          addr_last_i,
    input  logic                       is_big_i,
    input  logic [ADDR_W-1:0]          find_addr_i,
    output logic                       addr_in_range_o,
    output logic                       addr_is_first_o,
    output logic                       hit_big_o,
    output logic [ADDR_W-1:0]          read_o,
    output logic [ADDR_W-1:0]          read2_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       wrap_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  big_q;
    logic [ADDR_W-1:0] first_q [DEPTH];
    logic [ADDR_W-1:0] last_q  [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     newest_idx;
    logic              newest_vld;

    logic              wr_ok;
    logic              adjacent;
    logic              do_merge;
    logic              do_alloc;
    logic [ADDR_W-1:0] newest_first;
    logic [ADDR_W-1:0] newest_last;
    logic [ADDR_W-1:0] merged_first;
    logic [ADDR_W-1:0] merged_last;

    assign newest_first = first_q[newest_idx];
    assign newest_last  = last_q[newest_idx];
    assign wr_ok        = en_write_i && (addr_first_i <= addr_last_i);

    // Extra bit keeps last+1 from wrapping to zero at the top of memory
    assign adjacent =
        ({1'b0, addr_first_i} <= {1'b0, newest_last} + ONE) &&
        ({1'b0, addr_last_i} + ONE >= {1'b0, newest_first});

    assign do_merge = wr_ok && (MERGE_EN != 0) && newest_vld && adjacent;
    assign do_alloc = wr_ok && !do_merge;

    assign merged_first = (addr_first_i < newest_first) ? addr_first_i : newest_first;
    assign merged_last  = (addr_last_i > newest_last) ? addr_last_i : newest_last;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid      <= '0;
            big_q      <= '0;
            wr_ptr     <= '0;
            newest_idx <= '0;
            newest_vld <= 1'b0;
            count_o    <= '0;
            wrap_o     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                first_q[i] <= '0;
                last_q[i]  <= '0;
            end
        end else if (clr_i) begin
            valid      <= '0;
            wr_ptr     <= '0;
            newest_idx <= '0;
            newest_vld <= 1'b0;
            count_o    <= '0;
            wrap_o     <= 1'b0;
        end else begin
            wrap_o <= do_alloc && valid[wr_ptr];
            if (do_merge) begin
                first_q[newest_idx] <= merged_first;
                last_q[newest_idx]  <= merged_last;
                big_q[newest_idx]   <= big_q[newest_idx] | is_big_i;
            end
            if (do_alloc) begin
                valid[wr_ptr]   <= 1'b1;
                first_q[wr_ptr] <= addr_first_i;
                last_q[wr_ptr]  <= addr_last_i;
                big_q[wr_ptr]   <= is_big_i;
                newest_idx      <= wr_ptr;
                newest_vld      <= 1'b1;
                wr_ptr          <= wr_ptr + PW'(1);
                if (count_o != CW'(DEPTH))
                    count_o <= count_o + CW'(1);
            end
        end
    end

    logic [DEPTH-1:0] hit;
    logic [DEPTH-1:0] first_eq;
    logic             sel_hit;
    logic [PW-1:0]    sel_idx;
    logic [PW-1:0]    idx;

    always_comb begin
        hit      = '0;
        first_eq = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = valid[i] && (first_q[i] <= find_addr_i) &&
                     (find_addr_i <= last_q[i]);
            first_eq[i] = valid[i] && (find_addr_i == first_q[i]);
        end
    end

    // Walk oldest-to-newest so the newest hit is the last one written
    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        idx     = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = newest_idx - PW'(k);
            if (hit[idx]) begin
                sel_hit = 1'b1;
                sel_idx = idx;
            end
        end
    end

    assign addr_in_range_o = |hit;
    assign addr_is_first_o = |first_eq;
    assign hit_big_o       = sel_hit && big_q[sel_idx];
    assign read_o          = sel_hit ? first_q[sel_idx] : '0;
    assign read2_o         = sel_hit ? last_q[sel_idx] : '0;

endmodule

// File: tb/tb_bof_range_buffer.sv
// Scoreboard bench: two instances (merge on / merge off) against a
// queue-based age-ordered reference model.
module tb_bof_range_buffer;
    localparam int DEPTH = 8;
    localparam int AW    = 32;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst, clr, en, big;
    logic [AW-1:0] af, al, fa;

    logic          ir  [2];
    logic          isf [2];
    logic          hb  [2];
    logic [AW-1:0] rd  [2];
    logic [AW-1:0] rd2 [2];
    logic [CW-1:0] cnt [2];
    logic          wr  [2];

    always #5 clk = ~clk;

    bof_range_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .MERGE_EN(1)) dut_m (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_write_i(en),
        .addr_first_i(af), .addr_last_i(al), .is_big_i(big),
        .find_addr_i(fa), .addr_in_range_o(ir[0]), .addr_is_first_o(isf[0]),
        .hit_big_o(hb[0]), .read_o(rd[0]), .read2_o(rd2[0]),
        .count_o(cnt[0]), .wrap_o(wr[0])
    );

    bof_range_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .MERGE_EN(0)) dut_n (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_write_i(en),
        .addr_first_i(af), .addr_last_i(al), .is_big_i(big),
        .find_addr_i(fa), .addr_in_range_o(ir[1]), .addr_is_first_o(isf[1]),
        .hit_big_o(hb[1]), .read_o(rd[1]), .read2_o(rd2[1]),
        .count_o(cnt[1]), .wrap_o(wr[1])
    );

    typedef struct {
        logic          ir;
        logic          isf;
        logic          hb;
        logic [AW-1:0] rd;
        logic [AW-1:0] rd2;
        logic [CW-1:0] cnt;
        logic          wr;
    } exp_t;

    typedef struct {
        logic [AW-1:0] f;
        logic [AW-1:0] l;
        logic          b;
    } ent_t;

    typedef ent_t ent_q_t[$];

    ent_q_t m0, m1;
    bit     w0, w1;
    exp_t   sq0[$], sq1[$];
    int     n_chk = 0;
    int     n_fail = 0;

    // Model keeps entries oldest..newest; lookup scans from the newest end
    function automatic exp_t predict(ent_q_t q, bit w, logic [AW-1:0] a);
        exp_t e;
        e.ir = 0; e.isf = 0; e.hb = 0; e.rd = 0; e.rd2 = 0;
        e.cnt = CW'(q.size());
        e.wr = w;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (a == q[i].f) e.isf = 1;
            if (q[i].f <= a && a <= q[i].l) begin
                if (!e.ir) begin
                    e.hb = q[i].b; e.rd = q[i].f; e.rd2 = q[i].l;
                end
                e.ir = 1;
            end
        end
        return e;
    endfunction

    function automatic void model_wr(inout ent_q_t q, output bit w, input bit merge,
                                     input logic [AW-1:0] f, input logic [AW-1:0] l,
                                     input logic b);
        ent_t   n;
        longint nf, nl, xf, xl;
        w = 0;
        if (f > l) return;
        xf = longint'({32'b0, f});
        xl = longint'({32'b0, l});
        if (merge && q.size() > 0) begin
            n  = q[q.size()-1];
            nf = longint'({32'b0, n.f});
            nl = longint'({32'b0, n.l});
            if (xf <= nl + 1 && xl + 1 >= nf) begin
                if (f < n.f) n.f = f;
                if (l > n.l) n.l = l;
                n.b = n.b | b;
                q[q.size()-1] = n;
                return;
            end
        end
        if (q.size() == DEPTH) begin
            void'(q.pop_front());
            w = 1;
        end
        n.f = f; n.l = l; n.b = b;
        q.push_back(n);
    endfunction

    task automatic cyc(input bit r, input bit c, input bit e,
                       input logic [AW-1:0] f, input logic [AW-1:0] l,
                       input bit b, input logic [AW-1:0] fd);
        @(posedge clk);
        #1;
        rst = r; clr = c; en = e; af = f; al = l; big = b; fa = fd;
        if (r) begin
            m0.delete(); m1.delete(); w0 = 0; w1 = 0;
        end
        sq0.push_back(predict(m0, w0, fd));
        sq1.push_back(predict(m1, w1, fd));
        if (r || c) begin
            m0.delete(); m1.delete(); w0 = 0; w1 = 0;
        end else if (e) begin
            model_wr(m0, w0, 1'b1, f, l, b);
            model_wr(m1, w1, 1'b0, f, l, b);
        end else begin
            w0 = 0; w1 = 0;
        end
    endtask

    task automatic wrt(input logic [AW-1:0] f, input logic [AW-1:0] l, input bit b);
        cyc(0, 0, 1, f, l, b, f);
    endtask

    task automatic lk(input logic [AW-1:0] fd);
        cyc(0, 0, 0, '0, '0, 0, fd);
    endtask

    task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare(input int d, input exp_t e);
        string p;
        p = (d == 0) ? "merge" : "nomerge";
        chk({p, ".in_range"}, AW'(ir[d]), AW'(e.ir));
        chk({p, ".is_first"}, AW'(isf[d]), AW'(e.isf));
        chk({p, ".hit_big"}, AW'(hb[d]), AW'(e.hb));
        chk({p, ".read"}, rd[d], e.rd);
        chk({p, ".read2"}, rd2[d], e.rd2);
        chk({p, ".count"}, AW'(cnt[d]), AW'(e.cnt));
        chk({p, ".wrap"}, AW'(wr[d]), AW'(e.wr));
    endtask

    always @(negedge clk) begin
        if (sq0.size() > 0) compare(0, sq0.pop_front());
        if (sq1.size() > 0) compare(1, sq1.pop_front());
    end

    initial begin
        logic [AW-1:0] f, l, base;
        bit r, c, e;
        rst = 1; clr = 0; en = 0; af = 0; al = 0; big = 0; fa = 0;
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 32'h1000);
        lk(32'h1010);

        wrt(32'h1000, 32'h1020, 0);
        lk(32'h1010); lk(32'h1000); lk(32'h1021); lk(32'h1020);

        wrt(32'h2000, 32'h200F, 0);
        wrt(32'h2010, 32'h201F, 1);
        lk(32'h2018); lk(32'h2005);
        wrt(32'h3000, 32'h3004, 0);
        lk(32'h3004);

        cyc(0, 0, 1, 32'h4000, 32'h4008, 0, 32'h4004);
        lk(32'h4004);

        cyc(0, 1, 0, 0, 0, 0, 32'h4004);
        for (int k = 0; k <= 8; k++)
            wrt(32'h100 * k, 32'h100 * k + 32'hF, k[0]);
        lk(32'h0004); lk(32'h0804); lk(32'h0104); lk(32'h0100);

        cyc(0, 1, 0, 0, 0, 0, 0);
        wrt(32'h5000, 32'h50FF, 0);
        wrt(32'h5080, 32'h5090, 1);
        lk(32'h5085); lk(32'h50A0);
        cyc(0, 1, 1, 32'h5200, 32'h5210, 0, 32'h5085);
        lk(32'h5085); lk(32'h5200);

        cyc(0, 0, 1, 32'h6010, 32'h6000, 0, 32'h6008);
        lk(32'h6008);
        wrt(32'hFFFFFFF0, 32'hFFFFFFFF, 1);
        lk(32'hFFFFFFFF);
        wrt(32'h0, 32'h4, 0);
        lk(32'h2); lk(32'hFFFFFFF8);
        wrt(32'h5, 32'h9, 0);
        lk(32'h7);

        for (int n = 0; n < 3000; n++) begin
            r = ($urandom % 250) == 0;
            c = ($urandom % 60) == 0;
            e = ($urandom % 3) != 0;
            if (($urandom % 20) == 0) base = 32'hFFFFFF00;
            else base = 32'h7000;
            f = base + 32'($urandom_range(0, 200));
            l = f + 32'($urandom % 24);
            if (l < f) l = 32'hFFFFFFFF;
            if (($urandom % 12) == 0) begin
                l = f; f = f + 32'($urandom_range(1, 8));
            end
            cyc(r, c, e, f, l, $urandom % 2, base + 32'($urandom % 240));
        end
        lk(0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", AW'(sq0.size() + sq1.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
